// File: rtl/pixel_sink_pkg.sv
// Shared screen geometry, colour constants and the buffered pixel record
// used by the pixel sink and its FIFO.
package pixel_sink_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned ADDR_W   = 17;

  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BLACK = 3'b000;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] color;
  } pixel_t;

  localparam int unsigned PIXEL_W = $bits(pixel_t);

  typedef enum logic {
    WR_IDLE,
    WR_WRITE
  } wr_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Parameterised synchronous FIFO with occupancy count; head word is
// presented combinationally on data_o.
module pixel_fifo #(
  parameter  int unsigned WIDTH = 20,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pixel_sink.sv
// Pixel-plot stream sink: bounds-checks and buffers plotted pixels, then
// streams them to the framebuffer as single-cycle write strobes.
module pixel_sink #(
  parameter int unsigned SCREEN_W   = pixel_sink_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H   = pixel_sink_pkg::SCREEN_H,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = pixel_sink_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic [2:0]        color,
  input  logic              vga_en,
  output logic              ready,
  input  logic              fb_busy,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              idle,
  output logic [16:0]       pix_count,
  output logic [7:0]        oob_count
);
  import pixel_sink_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  pixel_t            in_pix, head_pix;
  logic [CNT_W-1:0]  fifo_count, count_nxt;
  logic              fifo_full, fifo_empty;
  logic              in_bounds, take, push, pop;
  wr_state_e         state_q, state_d;
  logic              ready_q, ready_d;
  logic              idle_q, idle_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        data_q;
  logic [16:0]       pix_q;
  logic [7:0]        oob_q;

  assign in_pix    = '{x: x, y: y, color: color};
  assign in_bounds = (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  assign take      = vga_en && ready_q;
  assign push      = take && in_bounds && !fifo_full;
  assign pop       = !fifo_empty && !fb_busy;
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

  pixel_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_pix),
    .data_o  (head_pix),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= WR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE:  if (pop) state_d = WR_WRITE;
      WR_WRITE: state_d = pop ? WR_WRITE : WR_IDLE;
      default:  state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    fb_we = (state_q == WR_WRITE);
  end

  // Shift-add form for the 320-wide screen; generic multiply otherwise.
  always_comb begin
    addr_d = (SCREEN_W == 320)
           ? ADDR_W'({head_pix.y, 8'b0}) + ADDR_W'({head_pix.y, 6'b0}) + ADDR_W'(head_pix.x)
           : ADDR_W'(32'(head_pix.y) * SCREEN_W + 32'(head_pix.x));
    ready_d = (32'(count_nxt) < FIFO_DEPTH);
    idle_d  = (count_nxt == '0) && (state_d == WR_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b1;
      idle_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= BLACK;
      pix_q   <= '0;
      oob_q   <= '0;
    end else begin
      ready_q <= ready_d;
      idle_q  <= idle_d;
      if (pop) begin
        addr_q <= addr_d;
        data_q <= head_pix.color;
      end
      if (fb_we) pix_q <= pix_q + 17'd1;
      if (take && !in_bounds && (oob_q != 8'hFF)) oob_q <= oob_q + 8'd1;
    end
  end

  assign ready     = ready_q;
  assign idle      = idle_q;
  assign fb_addr   = addr_q;
  assign fb_data   = data_q;
  assign pix_count = pix_q;
  assign oob_count = oob_q;

endmodule

// File: tb/tb_pixel_sink.sv
// Directed self-checking bench for pixel_sink.
module tb_pixel_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  x = '0;
  logic [7:0]  y = '0;
  logic [2:0]  color = '0;
  logic        vga_en = 1'b0;
  logic        fb_busy = 1'b0;
  logic        ready, fb_we, idle;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic [16:0] pix_count;
  logic [7:0]  oob_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int strobes = 0;
  int last_addr = 0;
  bit mon_en = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  pixel_sink #(
    .SCREEN_W   (320),
    .SCREEN_H   (240),
    .FIFO_DEPTH (4),
    .ADDR_W     (17)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .color     (color),
    .vga_en    (vga_en),
    .ready     (ready),
    .fb_busy   (fb_busy),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .idle      (idle),
    .pix_count (pix_count),
    .oob_count (oob_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && fb_we === 1'b1) begin
      strobes++;
      last_addr = int'(fb_addr);
      check("we_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("we_addr", 32'(fb_addr), 32'(mon_e[19:3]));
        check("we_data", 32'(fb_data), 32'(mon_e[2:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Producer: holds the pixel until the sink takes it or the budget runs out.
  task automatic offer(input int px, input int py, input int pc, input int maxc, output bit taken);
    logic [16:0] a;
    x      = px[8:0];
    y      = py[7:0];
    color  = pc[2:0];
    vga_en = 1'b1;
    taken  = 1'b0;
    for (int i = 0; i < maxc && !taken; i++) begin
      if (ready === 1'b1) begin
        taken = 1'b1;
        if (px < 320 && py < 240) begin
          a = 17'(py * 320 + px);
          exp_q.push_back({a, pc[2:0]});
        end
      end
      tick();
    end
    vga_en = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (!(idle === 1'b1 && exp_q.size() == 0) && n < maxc) begin
      tick();
      n++;
    end
    check("drain_done", 32'(idle === 1'b1 && exp_q.size() == 0), 32'd1);
  endtask

  initial begin
    bit t;
    int c0, s0;

    // Reset asserted mid-cycle
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_data", 32'(fb_data), 32'd0);
    check("rst_pix", 32'(pix_count), 32'd0);
    check("rst_oob", 32'(oob_count), 32'd0);
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single pixel: accept at edge N, strobe in the cycle after N+1
    offer(5, 2, 7, 2, t);
    check("sp_taken", 32'(t), 32'd1);
    check("sp_we_n", 32'(fb_we), 32'd0);
    check("sp_idle_n", 32'(idle), 32'd0);
    tick();
    check("sp_we_n1", 32'(fb_we), 32'd1);
    check("sp_addr", 32'(fb_addr), 32'd645);
    check("sp_data", 32'(fb_data), 32'd7);
    tick();
    check("sp_we_n2", 32'(fb_we), 32'd0);
    check("sp_pix", 32'(pix_count), 32'd1);
    check("sp_idle", 32'(idle), 32'd1);

    // Full-region stream at one pixel per clock
    c0 = cyc;
    s0 = strobes;
    for (int yy = 0; yy < 240; yy++)
      for (int xx = 120; xx < 200; xx++)
        offer(xx, yy, 0, 4, t);
    check("stream_cycles", 32'(cyc - c0), 32'd19200);
    wait_idle(20);
    check("stream_strobes", 32'(strobes - s0), 32'd19200);
    check("stream_last", 32'(last_addr), 32'd76679);
    check("stream_oob", 32'(oob_count), 32'd0);
    check("stream_pix", 32'(pix_count), 32'd19201);

    // Backpressure
    fb_busy = 1'b1;
    s0 = strobes;
    for (int i = 0; i < 4; i++) begin
      offer(10 + i, 100, i + 1, 1, t);
      check("bp_taken", 32'(t), 32'd1);
    end
    check("bp_ready_full", 32'(ready), 32'd0);
    check("bp_we_busy", 32'(fb_we), 32'd0);
    offer(14, 100, 5, 3, t);
    check("bp_held", 32'(t), 32'd0);
    check("bp_no_we", 32'(strobes - s0), 32'd0);
    fb_busy = 1'b0;
    offer(14, 100, 5, 4, t);
    check("bp_taken5", 32'(t), 32'd1);
    offer(15, 100, 6, 4, t);
    check("bp_taken6", 32'(t), 32'd1);
    wait_idle(20);
    check("bp_strobes", 32'(strobes - s0), 32'd6);
    check("bp_pix", 32'(pix_count), 32'd19207);

    // Bounds
    s0 = strobes;
    offer(320, 0, 1, 2, t);
    check("ob_taken_x", 32'(t), 32'd1);
    offer(0, 240, 2, 2, t);
    check("ob_taken_y", 32'(t), 32'd1);
    offer(511, 255, 3, 2, t);
    offer(319, 239, 7, 2, t);
    wait_idle(20);
    check("ob_count", 32'(oob_count), 32'd3);
    check("ob_strobes", 32'(strobes - s0), 32'd1);
    check("ob_last", 32'(last_addr), 32'd76799);
    check("ob_addr", 32'(fb_addr), 32'd76799);
    check("ob_pix", 32'(pix_count), 32'd19208);
    for (int i = 0; i < 260; i++) offer(400, 10, 0, 2, t);
    check("ob_sat", 32'(oob_count), 32'd255);
    check("ob_sat_nowr", 32'(strobes - s0), 32'd1);

    // Reset mid-stream with three entries buffered
    fb_busy = 1'b1;
    for (int i = 0; i < 3; i++) offer(i, 7, 4, 1, t);
    check("rm_idle_pre", 32'(idle), 32'd0);
    check("rm_ready_pre", 32'(ready), 32'd1);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    s0 = strobes;
    check("rm_we", 32'(fb_we), 32'd0);
    check("rm_ready", 32'(ready), 32'd1);
    check("rm_idle", 32'(idle), 32'd1);
    check("rm_pix", 32'(pix_count), 32'd0);
    check("rm_oob", 32'(oob_count), 32'd0);
    check("rm_addr", 32'(fb_addr), 32'd0);
    check("rm_data", 32'(fb_data), 32'd0);
    fb_busy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("rm_no_we", 32'(strobes - s0), 32'd0);
    check("rm_idle_post", 32'(idle), 32'd1);
    check("rm_pix_post", 32'(pix_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_sink.md
Name: pixel_sink

Overview:
- Receiving end of the pixel-plot stream that the screen-clear and tile-draw engines drive (x, y, color, vga_en).
- Accepts plotted pixels, rejects off-screen coordinates and buffers accepted pixels in a small FIFO.
- Converts each buffered pixel to a linear framebuffer address and issues single-cycle write strobes to the framebuffer.
- Honours a busy/stall signal from the framebuffer side, which is owned by VGA scan-out.

Parameters:
- SCREEN_W, 320, visible width in pixels. x is valid for 0..SCREEN_W-1.
- SCREEN_H, 240, visible height in lines. y is valid for 0..SCREEN_H-1.
- FIFO_DEPTH, 4, number of pixel entries buffered. Must be a power of two, at least 2.
- ADDR_W, 17, framebuffer address width. ceil(log2(320*240)) = 17.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- x  in  9  pixel column from the drawing engine.
- y  in  8  pixel row from the drawing engine.
- color  in  3  pixel colour, RGB 1 bit each (3'b111 = white).
- vga_en  in  1  plot request. A pixel is offered in every cycle where this is high.
- ready  out  1  high when the sink can accept a pixel this cycle.
- fb_busy  in  1  framebuffer stall. While high, no write is issued.
- fb_we  out  1  framebuffer write strobe, one cycle per pixel.
- fb_addr  out  ADDR_W  linear address, y*SCREEN_W + x.
- fb_data  out  3  colour to write.
- idle  out  1  high when the FIFO is empty and no write is pending.
- pix_count  out  17  number of fb_we strobes issued. Wraps modulo 2^17.
- oob_count  out  8  number of dropped off-screen pixels. Saturates at 255.

Behaviour:
- Reset (asynchronous, any cycle, including mid-stream):
  - FIFO emptied; fb_we = 0; fb_addr = 0; fb_data = 0.
  - ready = 1; idle = 1; pix_count = 0; oob_count = 0.
  - Pixels in flight are discarded and no write strobe is emitted after reset asserts.
- Accept:
  - A pixel is taken on the edge where vga_en = 1 and ready = 1.
  - If vga_en = 1 and ready = 0, the pixel is ignored. The producer must hold it; the sink keeps no record of it.
- Bounds check at accept:
  - If x >= SCREEN_W or y >= SCREEN_H, the pixel is not pushed and oob_count increments (saturating).
  - An out-of-bounds pixel still counts as taken, so no retry is expected.
  - Example: x = 9'd320 is dropped; x = 9'd319 is kept.
- ready:
  - Registered, equal to (fifo_count < FIFO_DEPTH) after the current edge's push and pop.
  - A pop in the same cycle does not raise ready combinationally.
- FIFO:
  - Holds {x, y, color}.
  - Push and pop in the same edge is allowed when non-empty; the count is unchanged.
  - Push while full cannot occur because ready = 0.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Write FSM with two states, IDLE and WRITE:
  - IDLE: if the FIFO is non-empty and fb_busy = 0, pop the head, compute the address, go to WRITE.
  - WRITE: fb_we = 1 for exactly this cycle. Then:
    - if the FIFO is non-empty and fb_busy = 0, pop the next entry and stay in WRITE (back-to-back, 1 pixel/cycle);
    - otherwise return to IDLE.
  - fb_busy only blocks pops. A write already registered completes regardless of fb_busy.
- Address arithmetic:
  - fb_addr = (y<<8) + (y<<6) + x, all zero-extended to ADDR_W. This applies to the default SCREEN_W = 320; generic widths use y*SCREEN_W + x.
  - Maximum value 76799 (y = 239, x = 319), which fits in 17 bits.
  - Address and data are registered together with fb_we.
- Latency:
  - With the FIFO empty and fb_busy low, a pixel accepted at edge N produces fb_we = 1 in the cycle after edge N+1.
  - Sustained throughput is 1 pixel/clock while fb_busy stays low.
- Counters:
  - pix_count increments on every cycle where fb_we = 1.
  - It wraps from 2^17-1 to 0.
- idle:
  - idle = FIFO empty and state == IDLE, registered.

Decomposition:
- Shared package:
  - SCREEN_W, SCREEN_H, ADDR_W;
  - colour constants WHITE = 3'b111 and BLACK = 3'b000;
  - pixel record layout {x[8:0], y[7:0], color[2:0]}, 20 bits.
- One sub-module: pixel_fifo, a parameterised synchronous FIFO with count, full and empty. Instantiate it once.

Test Plan:
- Reset state: assert reset mid-cycle -> all outputs go to their reset values immediately, with ready = 1 and idle = 1.
- Single pixel:
  - stimulus: x = 5, y = 2, color = 3'b111, one cycle of vga_en, fb_busy = 0;
  - response: one fb_we pulse with fb_addr = 645 and fb_data = 7 at edge N+2; pix_count = 1; idle returns to 1.
- Full-region stream:
  - stimulus: clear pass over x = 120..199, y = 0..239 with fb_busy = 0;
  - response: 19200 strobes, contiguous per row; last fb_addr = 239*320+199 = 76679; oob_count = 0.
- Backpressure:
  - stimulus: fb_busy = 1, then 6 pixels offered;
  - response: 4 accepted, ready = 0 from the edge after the 4th push, no fb_we;
  - then release fb_busy: 4 strobes in order, the held pixels are accepted and written in order.
- Bounds:
  - stimulus: (320, 0), (0, 240), (511, 255), (319, 239);
  - response: oob_count = 3; one write at addr 76799.
- Reset mid-stream:
  - stimulus: FIFO holding 3 entries, then reset asserted;
  - response: no further fb_we; FIFO empty; pix_count = 0.
